vx_lru_repl_ctrl: RTL and testbench
===================================

# vx_lru_repl_ctrl

Per-set LRU replacement controller for the set-associative cache. It keeps one LRU ordering per set and serves two requesters: hit-touch updates from the tag-match stage and victim-select requests from the fill/MSHR path. Requests are arbitrated round-robin and serialized through a small FSM, so each set's ordering changes atomically, one operation at a time.

## Interface
- NUM_SETS, default 4: number of cache sets; power of 2, ≥2.
- NUM_WAYS, default 4: ways per set; power of 2, ≥2.
- SET_W, default CLOG2(NUM_SETS): set index width.
- WAY_W, default CLOG2(NUM_WAYS): way index width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- touch_valid  in  1  hit-touch request.
- touch_set  in  SET_W  set of hit.
- touch_way  in  WAY_W  way that hit; becomes MRU.
- touch_ready  out  1  touch request accepted this cycle when high with touch_valid.
- victim_valid  in  1  victim-select request.
- victim_set  in  SET_W  set needing a fill.
- victim_ready  out  1  victim request accepted this cycle when high with victim_valid.
- victim_rsp_valid  out  1  one-cycle pulse carrying the selected victim.
- victim_rsp_set  out  SET_W  set of the response.
- victim_rsp_way  out  WAY_W  LRU way chosen; it becomes MRU.
- init_busy  out  1  high while the ordering table is being initialized.

## Operation
- Storage: order[s][p] for each set s and position p = 0..NUM_WAYS-1. Position 0 is LRU and NUM_WAYS-1 is MRU. Each set always holds a permutation of 0..NUM_WAYS-1.
- FSM states: INIT, IDLE, UPDATE.
- INIT
  - Entered on reset.
  - Writes order[s][p] = p for one set per cycle, using an init counter that runs 0..NUM_SETS-1.
  - Goes to IDLE after the last set is written.
  - init_busy = 1 and both ready signals = 0 while in INIT.
- IDLE arbitration
  - rr_ptr: 0 favours touch, 1 favours victim.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester named by rr_ptr is granted, and rr_ptr flips to the other requester.
  - A single grant leaves rr_ptr unchanged.
  - ready = (state == IDLE) && granted. Ready may depend combinationally on both valids; valid must not depend on ready.
- On a grant:
  - Latch op type, set, and way (touch only).
  - Read order[set] into a working register.
  - Go to UPDATE.
- UPDATE, touch
  - Find position k where order == touch_way.
  - Shift positions k+1..NUM_WAYS-1 down by one and write touch_way at MRU.
  - If k == NUM_WAYS-1, the ordering is unchanged.
- UPDATE, victim
  - victim_rsp_way = order[set][0].
  - Rotate the ordering left by one, so the old LRU way moves to MRU.
  - victim_rsp_valid = 1 for exactly this cycle, with victim_rsp_set = the latched set.
  - The response has no backpressure and the consumer must always accept it.
- UPDATE always returns to IDLE on the next cycle.
- Reset values: state = INIT, rr_ptr = 0, init counter = 0, victim_rsp_valid = 0, victim_rsp_set = 0, victim_rsp_way = 0, touch_ready = 0, victim_ready = 0, init_busy = 1.

## Timing
- INIT lasts exactly NUM_SETS cycles after reset deasserts. The first request can be accepted in cycle NUM_SETS.
- Request accepted at cycle N (IDLE). UPDATE occurs at N+1. For a victim request, victim_rsp_valid is high at N+1.
- The ordering write is visible to a request accepted at N+2. Peak throughput is one operation per 2 cycles.
- Back-to-back operations on the same set see the prior update, because operations are serialized and no bypass is needed.
- Reset asserted mid-operation:
  - Any in-flight UPDATE is discarded.
  - victim_rsp_valid is 0 in the cycle after reset.
  - Re-initialization restarts from set 0.
- Ready is 0 during UPDATE. Requesters hold valid and payload stable until accepted.

## Test plan
- Reset with NUM_SETS=4: init_busy is high for 4 cycles, then low, and ready rises. Four victim requests to set 2 then return ways 0, 1, 2, 3 in order, each with victim_rsp_valid high at acceptance+1.
- Touch set 1 way 0, then issue a victim request to set 1: response way is 1, and the ordering becomes [2,3,0,1].
- Touch set 3 way 3 on a fresh ordering: no change, and the next victim request to set 3 returns 0. Touch way 1, then issue victims: the returned sequence is 0, 2, 3, 1.
- Hold touch_valid and victim_valid high continuously: grants alternate touch, victim, touch, …; a new request is accepted every second cycle with no starvation.
- Issue a victim request, then assert reset in its UPDATE cycle: no response pulse appears after reset, INIT repeats for NUM_SETS cycles, and the next victim request to that set returns way 0.
- Interleave victim requests on sets 0 and 1: each set's LRU sequence (0, 1, 2, 3) is independent and unaffected by the other.

Source files
------------

// File: rtl/vx_lru_repl_ctrl.sv
// Per-set true-LRU replacement controller.
// Serializes hit-touch and victim-select requests (round-robin) through an INIT/IDLE/UPDATE FSM.
module vx_lru_repl_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch_valid,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    output logic             touch_ready,
    input  logic             victim_valid,
    input  logic [SET_W-1:0] victim_set,
    output logic             victim_ready,
    output logic             victim_rsp_valid,
    output logic [SET_W-1:0] victim_rsp_set,
    output logic [WAY_W-1:0] victim_rsp_way,
    output logic             init_busy
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPDATE
    } state_t;

    state_t           r_state;
    logic             r_rr;
    logic [SET_W-1:0] r_init_cnt;
    logic             r_is_victim;
    logic [SET_W-1:0] r_set;
    logic [WAY_W-1:0] r_way;
    logic [WAY_W-1:0] r_work  [NUM_WAYS];
    logic [WAY_W-1:0] r_order [NUM_SETS][NUM_WAYS];
    logic             r_rsp_valid;
    logic [SET_W-1:0] r_rsp_set;
    logic [WAY_W-1:0] r_rsp_way;

    logic             w_grant_touch;
    logic             w_grant_victim;
    logic             w_idle;
    logic             w_seen;
    logic [WAY_W-1:0] w_next  [NUM_WAYS];

    // Contention is resolved by r_rr; a lone requester always wins.
    assign w_idle         = !reset && (r_state == ST_IDLE);
    assign w_grant_touch  = touch_valid  && (!victim_valid || !r_rr);
    assign w_grant_victim = victim_valid && (!touch_valid  ||  r_rr);
    assign touch_ready    = w_idle && w_grant_touch;
    assign victim_ready   = w_idle && w_grant_victim;

    assign victim_rsp_valid = r_rsp_valid;
    assign victim_rsp_set   = r_rsp_set;
    assign victim_rsp_way   = r_rsp_way;
    assign init_busy        = (r_state == ST_INIT);

    // NOTE: w_seen is a blocking scratch flag; it and w_next get defaults first so no latch is inferred.
    always_comb begin
        w_seen = 1'b0;
        w_next = r_work;
        if (r_is_victim) begin
            for (int p = 0; p < NUM_WAYS - 1; p++) w_next[p] = r_work[p+1];
            w_next[NUM_WAYS-1] = r_work[0];
        end else begin
            for (int p = 0; p < NUM_WAYS - 1; p++) begin
                if (r_work[p] == r_way) w_seen = 1'b1;
                if (w_seen) w_next[p] = r_work[p+1];
            end
            w_next[NUM_WAYS-1] = r_way;
        end
    end

    // NOTE: r_order and r_work are not reset; INIT rewrites every set and r_work is loaded on each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_rr        <= 1'b0;
            r_init_cnt  <= '0;
            r_is_victim <= 1'b0;
            r_set       <= '0;
            r_way       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_set   <= '0;
            r_rsp_way   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    for (int p = 0; p < NUM_WAYS; p++) r_order[r_init_cnt][p] <= WAY_W'(p);
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == SET_W'(NUM_SETS - 1)) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_grant_touch || w_grant_victim) begin
                        r_is_victim <= w_grant_victim;
                        r_set       <= w_grant_victim ? victim_set : touch_set;
                        r_way       <= touch_way;
                        r_work      <= r_order[w_grant_victim ? victim_set : touch_set];
                        if (w_grant_victim) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_set   <= victim_set;
                            r_rsp_way   <= r_order[victim_set][0];
                        end
                        if (touch_valid && victim_valid) r_rr <= ~r_rr;
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_order[r_set] <= w_next;
                    r_state        <= ST_IDLE;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vx_lru_repl_ctrl.sv
// Self-checking bench for vx_lru_repl_ctrl: directed table, contention run, random ops vs a queue-based LRU model.
module tb_vx_lru_repl_ctrl;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 4;
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int WAY_W    = $clog2(NUM_WAYS);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             touch_valid = 1'b0;
    logic [SET_W-1:0] touch_set = '0;
    logic [WAY_W-1:0] touch_way = '0;
    logic             touch_ready;
    logic             victim_valid = 1'b0;
    logic [SET_W-1:0] victim_set = '0;
    logic             victim_ready;
    logic             victim_rsp_valid;
    logic [SET_W-1:0] victim_rsp_set;
    logic [WAY_W-1:0] victim_rsp_way;
    logic             init_busy;

    int n_pass  = 0;
    int n_total = 0;

    // LRU list per set: front is least recently used.
    int model_q[NUM_SETS][$];

    typedef struct {
        bit is_v;
        int set;
        int way;
        int exp;
    } vec_t;

    vec_t vecs[$];

    vx_lru_repl_ctrl #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
        .clk              (clk),
        .reset            (reset),
        .touch_valid      (touch_valid),
        .touch_set        (touch_set),
        .touch_way        (touch_way),
        .touch_ready      (touch_ready),
        .victim_valid     (victim_valid),
        .victim_set       (victim_set),
        .victim_ready     (victim_ready),
        .victim_rsp_valid (victim_rsp_valid),
        .victim_rsp_set   (victim_rsp_set),
        .victim_rsp_way   (victim_rsp_way),
        .init_busy        (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            model_q[s].delete();
            for (int w = 0; w < NUM_WAYS; w++) model_q[s].push_back(w);
        end
    endfunction

    function automatic int model_victim(input int s);
        int v;
        v = model_q[s].pop_front();
        model_q[s].push_back(v);
        return v;
    endfunction

    function automatic void model_touch(input int s, input int w);
        for (int i = 0; i < model_q[s].size(); i++) begin
            if (model_q[s][i] == w) begin
                model_q[s].delete(i);
                break;
            end
        end
        model_q[s].push_back(w);
    endfunction

    // Called at posedge+1 with reset already high; returns at posedge+1 in IDLE.
    task automatic init_seq();
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_rsp_valid", victim_rsp_valid, 0);
        check("rst_rsp_set", victim_rsp_set, 0);
        check("rst_rsp_way", victim_rsp_way, 0);
        model_reset();
        touch_valid = 1'b1;
        touch_set   = '0;
        touch_way   = '0;
        for (int i = 0; i < NUM_SETS; i++) begin
            #1;
            check("init_busy_high", init_busy, 1);
            check("init_ready_low", touch_ready, 0);
            @(posedge clk); #1;
        end
        #1;
        check("init_busy_low", init_busy, 0);
        check("idle_ready_high", touch_ready, 1);
        touch_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Starts and ends at posedge+1; exp_tbl < 0 means expect the model's victim.
    task automatic do_op(input bit is_v, input int s, input int w, input int exp_tbl);
        bit ok;
        int exp_w;
        if (is_v) begin
            victim_valid = 1'b1;
            victim_set   = SET_W'(s);
        end else begin
            touch_valid = 1'b1;
            touch_set   = SET_W'(s);
            touch_way   = WAY_W'(w);
        end
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (is_v ? victim_ready : touch_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("op_accept", int'(ok), 1);
        if (!ok) begin
            touch_valid  = 1'b0;
            victim_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        touch_valid  = 1'b0;
        victim_valid = 1'b0;
        if (is_v) begin
            exp_w = model_victim(s);
            if (exp_tbl >= 0) exp_w = exp_tbl;
            check("rsp_valid", victim_rsp_valid, 1);
            check("rsp_set", victim_rsp_set, s);
            check("rsp_way", victim_rsp_way, exp_w);
        end else begin
            model_touch(s, w);
            check("touch_no_rsp", victim_rsp_valid, 0);
        end
        @(posedge clk); #1;
        if (is_v) check("rsp_pulse_end", victim_rsp_valid, 0);
    endtask

    initial begin
        bit exp_v;
        bit pend;
        bit expect_ready;
        bit any;
        int pw;
        int accepts;

        // Interleaved sets 0/1, set 2 sweep, touch-then-victim on set 1, MRU touch on set 3.
        for (int i = 0; i < NUM_WAYS; i++) begin
            vecs.push_back('{1'b1, 0, 0, i});
            vecs.push_back('{1'b1, 1, 0, i});
        end
        for (int i = 0; i < NUM_WAYS; i++) vecs.push_back('{1'b1, 2, 0, i});
        vecs.push_back('{1'b0, 1, 0, -1});
        vecs.push_back('{1'b1, 1, 0, 1});
        vecs.push_back('{1'b1, 1, 0, 2});
        vecs.push_back('{1'b1, 1, 0, 3});
        vecs.push_back('{1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 3, 3, -1});
        vecs.push_back('{1'b0, 3, 1, -1});
        vecs.push_back('{1'b1, 3, 0, 0});
        vecs.push_back('{1'b1, 3, 0, 2});
        vecs.push_back('{1'b1, 3, 0, 3});
        vecs.push_back('{1'b1, 3, 0, 1});

        #1;
        init_seq();

        foreach (vecs[i]) do_op(vecs[i].is_v, vecs[i].set, vecs[i].way, vecs[i].exp);

        // Both requesters held: grants alternate starting with touch, one every 2 cycles.
        touch_valid  = 1'b1;
        touch_set    = '0;
        touch_way    = WAY_W'(2);
        victim_valid = 1'b1;
        victim_set   = '0;
        exp_v        = 1'b0;
        pend         = 1'b0;
        expect_ready = 1'b1;
        accepts      = 0;
        pw           = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (pend) begin
                check("arb_rsp_valid", victim_rsp_valid, 1);
                check("arb_rsp_way", victim_rsp_way, pw);
                pend = 1'b0;
            end else begin
                check("arb_rsp_idle", victim_rsp_valid, 0);
            end
            if (c < 11) begin
                any = touch_ready | victim_ready;
                check("arb_ready_phase", any, expect_ready);
                check("arb_single_grant", touch_ready & victim_ready, 0);
                if (any) begin
                    check("arb_kind", victim_ready, exp_v);
                    if (victim_ready) begin
                        pw   = model_victim(0);
                        pend = 1'b1;
                    end else begin
                        model_touch(0, 2);
                    end
                    exp_v = !exp_v;
                    accepts++;
                end
                expect_ready = !any;
            end else begin
                touch_valid  = 1'b0;
                victim_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("arb_accepts", accepts, 6);

        for (int i = 0; i < 80; i++)
            do_op(1'($urandom_range(0, 1)), $urandom_range(0, NUM_SETS - 1),
                  $urandom_range(0, NUM_WAYS - 1), -1);

        // Reset during a victim's UPDATE cycle.
        victim_valid = 1'b1;
        victim_set   = SET_W'(2);
        pend = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (victim_ready) begin
                pend = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("rst_mid_accept", pend, 1);
        @(posedge clk); #1;
        victim_valid = 1'b0;
        check("rst_mid_update_rsp", victim_rsp_valid, int'(pend));
        reset = 1'b1;
        init_seq();
        do_op(1'b1, 2, 0, 0);
        do_op(1'b1, 2, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
